io_event_generator: RTL
=======================

Name: io_event_generator

Overview:
Programmable event pulse-train generator. It is the transmit-side companion of the uDMA event counter, producing the single-cycle event strobes that a counter consumes. Software or a peripheral FSM configures a period and an event count, then pulses start. The block emits evenly spaced one-cycle event pulses and signals done. It sits in uDMA common logic, driving peripheral event inputs or test stimulus.

Parameters:
COUNTER_WIDTH, 6, width of the event-count config and the emitted-event counter
PERIOD_WIDTH, 16, width of the period config and the internal period down-counter

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset, asynchronous, active-low
start_i  input  1  start pulse; accepted only in IDLE
stop_i  input  1  abort; has priority over start_i and over any due event
cfg_period_i  input  PERIOD_WIDTH  event spacing minus one (0 = event every cycle)
cfg_num_i  input  COUNTER_WIDTH  number of events to emit; 0 = continuous until stop
event_o  output  1  registered one-cycle event strobe
busy_o  output  1  high while state is RUN
done_o  output  1  registered one-cycle pulse, coincident with the final event of a finite train
event_count_o  output  COUNTER_WIDTH  events emitted since last accepted start

Behaviour:
- Reset: state IDLE; event_o=0, done_o=0, busy_o=0, event_count_o=0; period counter=0; latched config=0.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.
- States: IDLE, RUN. busy_o = (state==RUN).
- IDLE, rising edge with start_i=1 and stop_i=0:
  - latch cfg_period_i and cfg_num_i;
  - set event_o<=1, event_count_o<=1, period_cnt<=cfg_period_i.
  - If cfg_num_i==1: done_o<=1 and stay IDLE. Otherwise go to RUN.
  - Result: first event appears in the cycle after start is sampled (latency 1).
- IDLE, any other case: event_o<=0, done_o<=0. event_count_o holds its last value.
- RUN, each edge:
  - stop_i=1: state<=IDLE, event_o<=0, done_o<=0. event_count_o holds. No done pulse.
  - else if period_cnt==0: event_o<=1, event_count_o<=event_count_o+1 (mod 2^COUNTER_WIDTH), period_cnt<=latched period.
    - If latched num!=0 and event_count_o+1==latched num: done_o<=1, state<=IDLE.
  - else: period_cnt<=period_cnt-1, event_o<=0, done_o<=0.
- Event spacing is exactly latched_period+1 cycles, rising edge to rising edge. With period 0, event_o stays high on consecutive cycles, one event per cycle.
- Final-event cycle: event_o=1, done_o=1, busy_o=0.
- Config inputs are ignored while RUN; changes take effect only at the next accepted start.
- start_i while RUN is ignored: no restart, counters unaffected. start_i with stop_i in IDLE: stop wins, stays IDLE.
- Continuous mode (num=0): event_count_o wraps 2^COUNTER_WIDTH-1 -> 0 and never terminates. Only stop_i or reset ends it.
- Count compare is done at COUNTER_WIDTH bits; num=2^COUNTER_WIDTH-1 is legal.
- Reset asserted mid-run: immediate return to reset values. No done, no partial pulse after deassertion.
- A new start accepted in the cycle after done_o is legal. Back-to-back trains need no idle gap beyond that one cycle.

Test Plan:
- period=2, num=3, start sampled at edge 0 -> event_o high in cycles 1,4,7 only; done_o high in cycle 7 only; busy_o high cycles 1-6; event_count_o=3 afterwards.
- period=0, num=4 -> event_o high cycles 1-4 continuous; done_o in cycle 4; event_count_o steps 1,2,3,4.
- num=1, period=100 -> single event and done_o in cycle 1; busy_o never asserts.
- Continuous mode, COUNTER_WIDTH=6, period=0, then stop at cycle 70 -> 69 events; count wraps 63->0 at event 64; event_count_o=5 at stop; no done_o; busy_o low next cycle.
- period=3, num=5; pulse start again mid-train and change cfg_period_i -> ignored, spacing stays 4. Stop coinciding with a due event -> no event emitted.
- Assert rstn_i low mid-train (after 2 events) -> all outputs 0 immediately. After deassertion, no events until a new start.

Source files
------------

// File: rtl/io_event_generator.sv
// io_event_generator: evenly spaced one-cycle event pulse trains; start_i/stop_i/cfg_period_i/cfg_num_i in, event_o/busy_o/done_o/event_count_o out
module io_event_generator #(
  parameter int COUNTER_WIDTH = 6,
  parameter int PERIOD_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [PERIOD_WIDTH-1:0]  cfg_period_i,
  input  logic [COUNTER_WIDTH-1:0] cfg_num_i,
  output logic                     event_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [COUNTER_WIDTH-1:0] event_count_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [PERIOD_WIDTH-1:0] period_cnt, period_cnt_n, lat_period, lat_period_n;
  logic [COUNTER_WIDTH-1:0] lat_num, lat_num_n, count_n, count_inc;
  logic event_n, done_n;
  assign busy_o = state == RUN;
  assign count_inc = event_count_o + 1'b1;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state         <= IDLE;
      period_cnt    <= '0;
      lat_period    <= '0;
      lat_num       <= '0;
      event_count_o <= '0;
      event_o       <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state         <= state_n;
      period_cnt    <= period_cnt_n;
      lat_period    <= lat_period_n;
      lat_num       <= lat_num_n;
      event_count_o <= count_n;
      event_o       <= event_n;
      done_o        <= done_n;
    end
  always_comb begin
    state_n      = state;
    period_cnt_n = period_cnt;
    lat_period_n = lat_period;
    lat_num_n    = lat_num;
    count_n      = event_count_o;
    event_n      = 1'b0;
    done_n       = 1'b0;
    if (state == IDLE) begin
      if (start_i && !stop_i) begin
        lat_period_n = cfg_period_i;
        lat_num_n    = cfg_num_i;
        period_cnt_n = cfg_period_i;
        count_n      = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
        event_n      = 1'b1;
        done_n       = cfg_num_i == {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
        state_n      = done_n ? IDLE : RUN;
      end
    end else if (stop_i) begin
      state_n = IDLE;
    end else if (period_cnt == '0) begin
      event_n      = 1'b1;
      count_n      = count_inc;
      period_cnt_n = lat_period;
      done_n       = lat_num != '0 && count_inc == lat_num;
      state_n      = done_n ? IDLE : RUN;
    end else begin
      period_cnt_n = period_cnt - 1'b1;
    end
  end
endmodule
